// File: rtl/hazard_dest_tracker.sv
// Producer side of the pipeline hazard check.
// Tracks the destination register and write-back enable of the instructions
// in EXE and MEM, and inserts bubbles into EXE on a hazard stall or a branch
// flush. Also exports a per-register busy mask and saturating event counters
// for debug.
module hazard_dest_tracker #(
  parameter int ADDR_W    = 4,
  parameter int REG_COUNT = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    id_dest,
  input  logic                 id_wb_en,
  input  logic                 id_valid,
  input  logic                 hazard,
  input  logic                 flush,
  input  logic                 freeze,
  output logic [ADDR_W-1:0]    exe_dest,
  output logic                 exe_wb_en,
  output logic [ADDR_W-1:0]    mem_dest,
  output logic                 mem_wb_en,
  output logic [REG_COUNT-1:0] busy_mask,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic bubble;

  // Flush and hazard both replace the ID instruction with a bubble in EXE.
  assign bubble = flush | hazard;

  // EXE/MEM stage registers; freeze holds everything, rst clears even under freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_dest  <= '0;
      exe_wb_en <= 1'b0;
      mem_dest  <= '0;
      mem_wb_en <= 1'b0;
    end else if (!freeze) begin
      mem_dest  <= exe_dest;
      mem_wb_en <= exe_wb_en;
      if (bubble) begin
        exe_dest  <= '0;
        exe_wb_en <= 1'b0;
      end else begin
        exe_dest  <= id_dest;
        exe_wb_en <= id_wb_en & id_valid;
      end
    end
  end

  // Saturating bubble counters; a flush is counted as a flush even if hazard is also high.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (!freeze) begin
      if (flush) begin
        if (flush_count != CNT_MAX) begin
          flush_count <= flush_count + 1'b1;
        end
      end else if (hazard) begin
        if (stall_count != CNT_MAX) begin
          stall_count <= stall_count + 1'b1;
        end
      end
    end
  end

  // Busy mask decoded straight from the stage registers, no extra latency.
  always_comb begin
    busy_mask = '0;
    if (exe_wb_en) begin
      busy_mask[exe_dest] = 1'b1;
    end
    if (mem_wb_en) begin
      busy_mask[mem_dest] = 1'b1;
    end
  end

endmodule
